// File: rtl/cp0_irq_ctrl.sv
// -----------------------------------------------------------------------------
// cp0_irq_ctrl
//
// Coprocessor-0 block for the pipelined MIPS core. It holds SR, Cause, EPC and
// PRId, and decides at the memory stage whether an interrupt or an exception is
// taken this cycle.
//
// Parameters
//   NUM_HWINT   number of hardware interrupt lines (1..6); line i -> bit 10+i
//   EDGE_MASK   bit i = 1: line i is edge-triggered and latched in pend
//   SYNC_STAGES input synchroniser depth (0..3, 0 = raw input used directly)
//   EXC_VECTOR  handler entry address
//   PRID        value returned for the PRId register
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-low reset, clears all state
//   we/addr/din mtc0 write (memory stage); addr also selects the mfc0 read
//   dout        mfc0 read data, combinational from addr
//   pc, bd_in   PC of the memory-stage instruction and its delay-slot flag
//   exc_code    pipeline exception code, 0 = no exception
//   eret        eret retiring this cycle
//   hwint       raw device interrupt lines
//   req         take the handler this cycle (flush, redirect to handler_pc)
//   handler_pc  constant EXC_VECTOR
//   epc         current EPC, the eret target
//   exl         SR.EXL
// -----------------------------------------------------------------------------
module cp0_irq_ctrl #(
  parameter int          NUM_HWINT   = 6,
  parameter logic [5:0]  EDGE_MASK   = 6'b000000,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_4180,
  parameter logic [31:0] PRID        = 32'h4350_5538
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [4:0]           addr,
  input  logic [31:0]          din,
  output logic [31:0]          dout,
  input  logic [31:0]          pc,
  input  logic                 bd_in,
  input  logic [4:0]           exc_code,
  input  logic                 eret,
  input  logic [NUM_HWINT-1:0] hwint,
  output logic                 req,
  output logic [31:0]          handler_pc,
  output logic [31:0]          epc,
  output logic                 exl
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // Only the implemented lines take part; upper mask bits are ignored.
  localparam logic [NUM_HWINT-1:0] EDGE_BITS = EDGE_MASK[NUM_HWINT-1:0];

  // Architectural state
  logic [NUM_HWINT-1:0] im_r;
  logic                 exl_r;
  logic                 ie_r;
  logic                 bd_r;
  logic [4:0]           exc_code_r;
  logic [29:0]          epc_r;       // EPC[31:2]; [1:0] are always zero
  logic [NUM_HWINT-1:0] pend_r;      // latched edge requests
  logic [NUM_HWINT-1:0] prev_r;      // previous synchronised value

  // Combinational helpers
  logic [NUM_HWINT-1:0] sync_s;
  logic [NUM_HWINT-1:0] ip_s;
  logic [NUM_HWINT-1:0] rise_s;
  logic [NUM_HWINT-1:0] clr_s;
  logic [5:0]           ip6_s;
  logic [5:0]           im6_s;
  logic                 irq_s;
  logic                 exc_s;
  logic                 req_s;
  logic                 wr_ok_s;
  logic                 sr_wr_s;
  logic                 cause_wr_s;
  logic                 epc_wr_s;
  logic [31:0]          epc_take_s;

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  if (SYNC_STAGES == 0) begin : g_nosync
    assign sync_s = hwint;
  end else begin : g_sync
    logic [NUM_HWINT-1:0] stage_r [SYNC_STAGES];

    // Shift raw lines through SYNC_STAGES flops
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int k = 0; k < SYNC_STAGES; k++) begin
          stage_r[k] <= {NUM_HWINT{1'b0}};
        end
      end else begin
        stage_r[0] <= hwint;
        for (int k = 1; k < SYNC_STAGES; k++) begin
          stage_r[k] <= stage_r[k-1];
        end
      end
    end

    assign sync_s = stage_r[SYNC_STAGES-1];
  end

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------

  // Pending bits, interrupt/exception decision and write qualification
  always_comb begin
    rise_s  = sync_s & ~prev_r & EDGE_BITS;
    // Level lines show the synchronised input; edge lines show the latch.
    ip_s    = (pend_r & EDGE_BITS) | (sync_s & ~EDGE_BITS);
    irq_s   = ie_r & ~exl_r & (|(ip_s & im_r));
    exc_s   = (exc_code != 5'd0) & ~exl_r;
    // Gate with reset so nothing is requested while reset is held low.
    req_s   = reset & (irq_s | exc_s);
    // A taken request discards any mtc0 in the same cycle.
    wr_ok_s    = we & ~req_s;
    sr_wr_s    = wr_ok_s & (addr == ADDR_SR);
    cause_wr_s = wr_ok_s & (addr == ADDR_CAUSE);
    epc_wr_s   = wr_ok_s & (addr == ADDR_EPC);
    if (cause_wr_s) begin
      clr_s = din[10 +: NUM_HWINT];
    end else begin
      clr_s = {NUM_HWINT{1'b0}};
    end
    // EPC points back at the branch when the faulting instruction is in its slot.
    if (bd_in) begin
      epc_take_s = pc - 32'd4;
    end else begin
      epc_take_s = pc;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------

  // Edge detection history and pending latches (set beats clear)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_r <= {NUM_HWINT{1'b0}};
      pend_r <= {NUM_HWINT{1'b0}};
    end else begin
      prev_r <= sync_s;
      pend_r <= (pend_r & ~clr_s) | rise_s;
    end
  end

  // SR: IM and IE follow mtc0; EXL is set on entry, cleared by eret
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_r  <= {NUM_HWINT{1'b0}};
      ie_r  <= 1'b0;
      exl_r <= 1'b0;
    end else begin
      if (sr_wr_s) begin
        im_r <= din[10 +: NUM_HWINT];
        ie_r <= din[0];
      end else begin
        im_r <= im_r;
        ie_r <= ie_r;
      end
      if (req_s) begin
        exl_r <= 1'b1;
      end else if (eret) begin
        exl_r <= 1'b0;
      end else if (sr_wr_s) begin
        exl_r <= din[1];
      end else begin
        exl_r <= exl_r;
      end
    end
  end

  // Cause.BD / Cause.ExcCode capture on a taken request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bd_r       <= 1'b0;
      exc_code_r <= 5'd0;
    end else if (req_s) begin
      bd_r <= bd_in;
      // Interrupts win, so their code replaces any concurrent exception.
      if (irq_s) begin
        exc_code_r <= 5'd0;
      end else begin
        exc_code_r <= exc_code;
      end
    end else begin
      bd_r       <= bd_r;
      exc_code_r <= exc_code_r;
    end
  end

  // EPC: captured on entry, otherwise writable by mtc0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      epc_r <= 30'd0;
    end else if (req_s) begin
      epc_r <= epc_take_s[31:2];
    end else if (epc_wr_s) begin
      epc_r <= din[31:2];
    end else begin
      epc_r <= epc_r;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path and outputs
  // ---------------------------------------------------------------------------

  // Widen the line-indexed fields to the fixed six-bit register layout
  always_comb begin
    ip6_s = 6'd0;
    im6_s = 6'd0;
    ip6_s[NUM_HWINT-1:0] = ip_s;
    im6_s[NUM_HWINT-1:0] = im_r;
  end

  // mfc0 read mux; unmapped registers read zero
  always_comb begin
    dout = 32'd0;
    case (addr)
      ADDR_SR:    dout = {16'd0, im6_s, 8'd0, exl_r, ie_r};
      ADDR_CAUSE: dout = {bd_r, 15'd0, ip6_s, 3'd0, exc_code_r, 2'd0};
      ADDR_EPC:   dout = {epc_r, 2'b00};
      ADDR_PRID:  dout = PRID;
      default:    dout = 32'd0;
    endcase
  end

  assign req        = req_s;
  assign handler_pc = EXC_VECTOR;
  assign epc        = {epc_r, 2'b00};
  assign exl        = exl_r;

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cp0_irq_ctrl
//
// Directed scenarios followed by randomized traffic. A behavioural model keeps
// the register fields as plain values and derives the synchronised view of each
// line from a history of sampled hwint values.
// -----------------------------------------------------------------------------
module tb_cp0_irq_ctrl;

  localparam int         NUM   = 6;
  localparam int         SYNC  = 2;
  localparam logic [5:0] EM    = 6'b000100;
  localparam logic [31:0] VEC  = 32'h0000_4180;
  localparam logic [31:0] PID  = 32'h4350_5538;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic [31:0] pc;
  logic        bd_in;
  logic [4:0]  exc_code;
  logic        eret;
  logic [5:0]  hwint;
  logic        req;
  logic [31:0] handler_pc;
  logic [31:0] epc;
  logic        exl;

  int n_tests = 0;
  int n_fail  = 0;

  cp0_irq_ctrl #(
    .NUM_HWINT(NUM), .EDGE_MASK(EM), .SYNC_STAGES(SYNC),
    .EXC_VECTOR(VEC), .PRID(PID)
  ) dut (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .din(din), .dout(dout),
    .pc(pc), .bd_in(bd_in), .exc_code(exc_code), .eret(eret), .hwint(hwint),
    .req(req), .handler_pc(handler_pc), .epc(epc), .exl(exl)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [5:0]  m_im, m_pend;
  logic        m_exl, m_ie, m_bd;
  logic [4:0]  m_code;
  logic [31:0] m_epc;
  logic [5:0]  hist [0:3];   // hist[0] = hwint sampled at the last edge

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_im = 6'd0; m_pend = 6'd0; m_exl = 1'b0; m_ie = 1'b0; m_bd = 1'b0;
    m_code = 5'd0; m_epc = 32'd0;
    for (int k = 0; k < 4; k++) hist[k] = 6'd0;
  endtask

  // Compare DUT against model for the current inputs, then advance one clock.
  // Called just after a falling edge with inputs already applied.
  task automatic tick();
    logic [5:0]  s, p, ip, rise, clr;
    logic        irq, exc, rq;
    logic [31:0] exp_dout;
    logic [5:0]  n_im, n_pend;
    logic        n_exl, n_ie, n_bd;
    logic [4:0]  n_code;
    logic [31:0] n_epc;
    #1;
    if (!reset) model_clear();
    s   = hist[SYNC-1];
    p   = hist[SYNC];
    ip  = (m_pend & EM) | (s & ~EM);
    irq = m_ie && !m_exl && ((ip & m_im) != 6'd0);
    exc = (exc_code != 5'd0) && !m_exl;
    rq  = reset && (irq || exc);
    case (addr)
      5'd12:   exp_dout = (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
      5'd13:   exp_dout = (32'(m_bd) << 31) | (32'(ip) << 10) | (32'(m_code) << 2);
      5'd14:   exp_dout = m_epc;
      5'd15:   exp_dout = PID;
      default: exp_dout = 32'd0;
    endcase
    chk("req",  {31'd0, req}, {31'd0, rq});
    chk("exl",  {31'd0, exl}, {31'd0, m_exl});
    chk("epc",  epc, m_epc);
    chk("dout", dout, exp_dout);
    chk("hpc",  handler_pc, VEC);

    n_im = m_im; n_exl = m_exl; n_ie = m_ie; n_bd = m_bd; n_code = m_code; n_epc = m_epc;
    if (rq) begin
      n_exl  = 1'b1;
      n_code = irq ? 5'd0 : exc_code;
      n_bd   = bd_in;
      n_epc  = (bd_in ? pc - 32'd4 : pc) & 32'hFFFF_FFFC;
    end else begin
      if (we && addr == 5'd12) begin
        n_im = din[15:10]; n_exl = din[1]; n_ie = din[0];
      end
      if (we && addr == 5'd14) n_epc = din & 32'hFFFF_FFFC;
      if (eret) n_exl = 1'b0;
    end
    clr    = (!rq && we && addr == 5'd13) ? din[15:10] : 6'd0;
    rise   = s & ~p & EM;
    n_pend = (m_pend & ~clr) | rise;

    @(posedge clk);
    if (reset) begin
      m_im = n_im; m_exl = n_exl; m_ie = n_ie; m_bd = n_bd; m_code = n_code;
      m_epc = n_epc; m_pend = n_pend;
      for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = hwint;
    end else begin
      model_clear();
    end
    @(negedge clk);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; din = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    model_clear();
    reset = 1'b0; we = 1'b0; addr = 5'd0; din = 32'd0; pc = 32'd0;
    bd_in = 1'b0; exc_code = 5'd0; eret = 1'b0; hwint = 6'h3F;

    // Reset then idle
    repeat (3) tick();
    reset = 1'b1; addr = 5'd13;
    #1;
    chk("rst_cause", dout, 32'd0);
    chk("rst_exl", {31'd0, exl}, 32'd0);
    chk("rst_epc", epc, 32'd0);
    chk("rst_req", {31'd0, req}, 32'd0);
    hwint = 6'h00;
    repeat (4) tick();
    mtc0(5'd13, 32'h0000_FC00);

    // Level interrupt on line 0
    mtc0(5'd12, 32'h0000_0401);
    hwint = 6'h01; pc = 32'h0000_2000; bd_in = 1'b0;
    tick();
    tick();
    chk("lvl_req", {31'd0, req}, 32'd1);
    tick();
    addr = 5'd13;
    #1;
    chk("lvl_exl", {31'd0, exl}, 32'd1);
    chk("lvl_cause", dout, 32'h0000_0400);
    chk("lvl_epc", epc, 32'h0000_2000);

    // eret with the level line still held
    eret = 1'b1;
    tick();
    eret = 1'b0;
    #1;
    chk("eret_exl", {31'd0, exl}, 32'd0);
    chk("eret_req", {31'd0, req}, 32'd1);
    tick();
    hwint = 6'h00;
    mtc0(5'd12, 32'h0000_0400);

    // Exception in a delay slot with IE=0
    exc_code = 5'd4; bd_in = 1'b1; pc = 32'h0000_3010;
    #1;
    chk("ds_req", {31'd0, req}, 32'd1);
    tick();
    exc_code = 5'd0; bd_in = 1'b0; addr = 5'd14;
    #1;
    chk("ds_epc_rd", dout, 32'h0000_300C);
    chk("ds_epc", epc, 32'h0000_300C);
    addr = 5'd13;
    #1;
    chk("ds_cause", dout, 32'h8000_0010);
    mtc0(5'd12, 32'h0000_0000);

    // Edge latch on line 2, clear, and set beating a coincident clear
    hwint = 6'h04;
    tick();
    hwint = 6'h00;
    tick();
    tick();
    addr = 5'd13;
    #1;
    chk("edge_set", (dout >> 12) & 32'd1, 32'd1);
    mtc0(5'd13, 32'h0000_1000);
    addr = 5'd13;
    #1;
    chk("edge_clr", (dout >> 12) & 32'd1, 32'd0);
    hwint = 6'h04;
    tick();
    hwint = 6'h00;
    tick();
    mtc0(5'd13, 32'h0000_1000);
    addr = 5'd13;
    #1;
    chk("edge_set_wins", (dout >> 12) & 32'd1, 32'd1);
    mtc0(5'd13, 32'h0000_1000);
    addr = 5'd13;
    #1;
    chk("edge_clr2", (dout >> 12) & 32'd1, 32'd0);

    // Interrupt beats exception; same-cycle EPC write discarded
    hwint = 6'h01;
    mtc0(5'd12, 32'h0000_0401);
    tick();
    exc_code = 5'd12; we = 1'b1; addr = 5'd14; din = 32'hDEAD_0000;
    pc = 32'h0000_5000; bd_in = 1'b0;
    #1;
    chk("pri_req", {31'd0, req}, 32'd1);
    tick();
    we = 1'b0; exc_code = 5'd0; addr = 5'd13;
    #1;
    chk("pri_cause", dout, 32'h0000_0400);
    chk("pri_epc", epc, 32'h0000_5000);
    hwint = 6'h00;
    mtc0(5'd12, 32'h0000_0000);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      reset    = ($urandom_range(0, 199) != 0);
      eret     = ($urandom_range(0, 9) == 0);
      we       = !eret && ($urandom_range(0, 3) == 0);
      addr     = ($urandom_range(0, 3) != 0) ? 5'(12 + $urandom_range(0, 3))
                                             : 5'($urandom_range(0, 31));
      din      = $urandom;
      pc       = $urandom;
      bd_in    = 1'($urandom_range(0, 1));
      exc_code = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      if ($urandom_range(0, 7) == 0) hwint = hwint ^ (6'd1 << $urandom_range(0, 5));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
